// File: rtl/param_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : param_cache_controller
// Brief    : Two-level direct-mapped cache controller (L1 + L2, one word per
//            line) in front of a handshaked backing memory. Reads allocate
//            into both levels on a full miss; writes are write-through and
//            write-allocate into both levels.
// Revision : 1.0 - initial release
// ============================================================================
module param_cache_controller #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 8,
  parameter int L1_IDX_W = 4,
  parameter int L2_IDX_W = 6,
  parameter int L2_LAT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              mode,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic              Wait,
  output logic              done,
  output logic              hit1,
  output logic              hit2,
  output logic [DATA_W-1:0] data_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int C_L1_LINES = 1 << L1_IDX_W;
  localparam int C_L2_LINES = 1 << L2_IDX_W;
  localparam int C_L1_TAG_W = ADDR_W - L1_IDX_W;
  localparam int C_L2_TAG_W = ADDR_W - L2_IDX_W;
  localparam int C_CNT_W    = (L2_LAT > 1) ? $clog2(L2_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    L2_ACC = 3'd2,
    MEM_RD = 3'd3,
    MEM_WR = 3'd4
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                mode_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [C_CNT_W-1:0]  cnt_q;

  logic                done_q;
  logic                hit1_q;
  logic                hit2_q;
  logic [DATA_W-1:0]   data_out_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic [C_L1_LINES-1:0] l1_valid_q;
  logic [C_L1_TAG_W-1:0] l1_tag_q  [C_L1_LINES];
  logic [DATA_W-1:0]     l1_data_q [C_L1_LINES];
  logic [C_L2_LINES-1:0] l2_valid_q;
  logic [C_L2_TAG_W-1:0] l2_tag_q  [C_L2_LINES];
  logic [DATA_W-1:0]     l2_data_q [C_L2_LINES];

  // Index/tag split of the latched request address and the hit decode.
  // The arrays only change when a request completes, so these stay valid
  // (and reflect pre-write presence) for the whole life of a request.
  logic [L1_IDX_W-1:0]   w_l1_idx;
  logic [C_L1_TAG_W-1:0] w_l1_tag;
  logic [L2_IDX_W-1:0]   w_l2_idx;
  logic [C_L2_TAG_W-1:0] w_l2_tag;
  logic                  w_l1_hit;
  logic                  w_l2_hit;

  assign w_l1_idx = addr_q[L1_IDX_W-1:0];
  assign w_l1_tag = addr_q[ADDR_W-1:L1_IDX_W];
  assign w_l2_idx = addr_q[L2_IDX_W-1:0];
  assign w_l2_tag = addr_q[ADDR_W-1:L2_IDX_W];
  assign w_l1_hit = l1_valid_q[w_l1_idx] && (l1_tag_q[w_l1_idx] == w_l1_tag);
  assign w_l2_hit = l2_valid_q[w_l2_idx] && (l2_tag_q[w_l2_idx] == w_l2_tag);

  assign Wait      = (state_q != IDLE);
  assign done      = done_q;
  assign hit1      = hit1_q;
  assign hit2      = hit2_q;
  assign data_out  = data_out_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Controller FSM: owns request latching, cache array updates, memory
  // handshake and all registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      mode_q      <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      hit1_q      <= 1'b0;
      hit2_q      <= 1'b0;
      data_out_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      l1_valid_q  <= '0;
      l2_valid_q  <= '0;
    end else begin
      // Status flags are single-cycle pulses; data_out holds.
      done_q <= 1'b0;
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= address;
            mode_q  <= mode;
            wdata_q <= data_in;
            state_q <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (mode_q) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= wdata_q;
            state_q     <= MEM_WR;
          end else if (w_l1_hit) begin
            done_q     <= 1'b1;
            hit1_q     <= 1'b1;
            hit2_q     <= w_l2_hit;
            data_out_q <= l1_data_q[w_l1_idx];
            state_q    <= IDLE;
          end else if (w_l2_hit) begin
            cnt_q   <= C_CNT_W'(L2_LAT - 1);
            state_q <= L2_ACC;
          end else begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= addr_q;
            state_q    <= MEM_RD;
          end
        end

        L2_ACC: begin
          if (cnt_q == '0) begin
            l1_valid_q[w_l1_idx] <= 1'b1;
            l1_tag_q[w_l1_idx]   <= w_l1_tag;
            l1_data_q[w_l1_idx]  <= l2_data_q[w_l2_idx];
            done_q     <= 1'b1;
            hit2_q     <= 1'b1;
            data_out_q <= l2_data_q[w_l2_idx];
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q - C_CNT_W'(1);
          end
        end

        MEM_RD: begin
          if (mem_ack) begin
            mem_req_q            <= 1'b0;
            l1_valid_q[w_l1_idx] <= 1'b1;
            l1_tag_q[w_l1_idx]   <= w_l1_tag;
            l1_data_q[w_l1_idx]  <= mem_rdata;
            l2_valid_q[w_l2_idx] <= 1'b1;
            l2_tag_q[w_l2_idx]   <= w_l2_tag;
            l2_data_q[w_l2_idx]  <= mem_rdata;
            done_q     <= 1'b1;
            data_out_q <= mem_rdata;
            state_q    <= IDLE;
          end
        end

        MEM_WR: begin
          if (mem_ack) begin
            mem_req_q            <= 1'b0;
            mem_we_q             <= 1'b0;
            l1_valid_q[w_l1_idx] <= 1'b1;
            l1_tag_q[w_l1_idx]   <= w_l1_tag;
            l1_data_q[w_l1_idx]  <= wdata_q;
            l2_valid_q[w_l2_idx] <= 1'b1;
            l2_tag_q[w_l2_idx]   <= w_l2_tag;
            l2_data_q[w_l2_idx]  <= wdata_q;
            done_q  <= 1'b1;
            hit1_q  <= w_l1_hit;
            hit2_q  <= w_l2_hit;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
